// File: rtl/ca_prng_pkg.sv
// Shared types and the elementary-CA rule lookup for the CA PRNG checker.
package ca_prng_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } ca_state_e;

    // nbhd is {left, centre, right}; boundary cells must already be zero-padded by the caller.
    function automatic logic ca_rule_bit(input logic [7:0] rule, input logic [2:0] nbhd);
        return rule[nbhd];
    endfunction

endpackage

// File: rtl/ca_rule_eval.sv
// Combinational one-step evaluation of an elementary CA with null (zero) boundary cells.
module ca_rule_eval
    import ca_prng_pkg::*;
#(
    parameter int unsigned ARRAY_WIDTH = 11,
    parameter logic [7:0]  RULE        = 8'd30
) (
    input  logic [ARRAY_WIDTH-1:0] i_cells,
    output logic [ARRAY_WIDTH-1:0] o_next
);

    logic [ARRAY_WIDTH+1:0] padded;

    always_comb begin
        padded = {1'b0, i_cells, 1'b0};
        o_next = '0;
        for (int unsigned i = 0; i < ARRAY_WIDTH; i++) begin
            o_next[i] = ca_rule_bit(RULE, padded[i +: 3]);
        end
    end

endmodule

// File: rtl/ca_prng_checker.sv
// Locks onto a CA PRNG stream, then flywheels its own prediction and flags mismatches.
// Define CA_PRNG_CHECKER_ERR_CNT_EN to build the saturating error counter on o_err_cnt.
module ca_prng_checker
    import ca_prng_pkg::*;
#(
    parameter int unsigned ARRAY_WIDTH = 11,
    parameter logic [7:0]  RULE        = 8'd30,
    parameter int unsigned LOCK_CNT    = 4,
    parameter int unsigned LOSS_CNT    = 3,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  logic [ARRAY_WIDTH-1:0] i_sig,
    output logic                   o_locked,
    output logic                   o_err,
    output logic [CNT_W-1:0]       o_err_cnt
);

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_TGT = 4'(LOSS_CNT);

    ca_state_e              state;
    logic [ARRAY_WIDTH-1:0] pred;
    logic [ARRAY_WIDTH-1:0] f_sig;
    logic [ARRAY_WIDTH-1:0] f_pred;
    logic [3:0]             match_cnt;
    logic [3:0]             miss_cnt;
    logic                   sig_match;
    logic                   sig_zero;
    logic                   err_hit;

    ca_rule_eval #(.ARRAY_WIDTH(ARRAY_WIDTH), .RULE(RULE)) u_eval_sig (
        .i_cells (i_sig),
        .o_next  (f_sig)
    );

    ca_rule_eval #(.ARRAY_WIDTH(ARRAY_WIDTH), .RULE(RULE)) u_eval_pred (
        .i_cells (pred),
        .o_next  (f_pred)
    );

    assign sig_match = (i_sig == pred);
    assign sig_zero  = (i_sig == '0);
    assign err_hit   = i_valid && (state == LOCKED) && !sig_match;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= HUNT;
            pred      <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            o_locked  <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_err <= err_hit;
            if (i_valid) begin
                unique case (state)
                    HUNT: begin
                        if (!sig_zero) begin
                            pred      <= f_sig;
                            match_cnt <= '0;
                            state     <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (sig_match) begin
                            pred      <= f_pred;
                            match_cnt <= match_cnt + 4'd1;
                            if (match_cnt + 4'd1 == LOCK_TGT) begin
                                state    <= LOCKED;
                                miss_cnt <= '0;
                                o_locked <= 1'b1;
                            end
                        end else if (sig_zero) begin
                            state <= HUNT;
                        end else begin
                            pred      <= f_sig;
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: the received word is never reloaded once locked.
                        pred <= f_pred;
                        if (sig_match) begin
                            miss_cnt <= '0;
                        end else begin
                            miss_cnt <= miss_cnt + 4'd1;
                            if (miss_cnt + 4'd1 == LOSS_TGT) begin
                                state    <= HUNT;
                                o_locked <= 1'b0;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

`ifdef CA_PRNG_CHECKER_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_cnt <= '0;
        end else if (err_hit && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

    assign o_err_cnt = err_cnt;
`else
    assign o_err_cnt = '0;
`endif

endmodule

// File: doc/ca_prng_checker.md
CA_PRNG_CHECKER -- requirements
Module: ca_prng_checker

Interface
REQ-001 Parameter ARRAY_WIDTH, 11, width of the checked CA grid word (minimum 3).
REQ-002 Parameter RULE, 30, 8-bit elementary CA rule; only 3-cell neighbourhoods are supported.
REQ-003 Parameter LOCK_CNT, 4, consecutive correct predictions required to declare lock (1..15).
REQ-004 Parameter LOSS_CNT, 3, consecutive mispredictions while locked that drop lock (1..15).
REQ-005 Parameter CNT_W, 16, width of the error counter.
REQ-006 Port i_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-007 Port i_rst, input, 1, reset, synchronous and active-high.
REQ-008 Port i_valid, input, 1, qualifies i_sig for the current cycle.
REQ-009 Port i_sig, input, ARRAY_WIDTH, received CA grid word from a generator.
REQ-010 Port o_locked, output, 1, high while in LOCKED.
REQ-011 Port o_err, output, 1, single-cycle mismatch pulse while locked.
REQ-012 Port o_err_cnt, output, CNT_W, saturating count of mismatches while locked.

Function
REQ-013 Next-state function f: next[i] = RULE[{c[i+1],c[i],c[i-1]}]; cells outside 0..ARRAY_WIDTH-1 read as 0 (null boundary).
REQ-014 States: HUNT, SYNC, LOCKED; cycles with i_valid low change no state, counter or prediction; o_err is low on them.
REQ-015 HUNT: valid non-zero i_sig loads pred = f(i_sig), clears match count and moves to SYNC; a valid all-zero i_sig is ignored and HUNT is kept.
REQ-016 SYNC: valid i_sig == pred increments match count and sets pred = f(pred); when the count reaches LOCK_CNT, go to LOCKED.
REQ-017 SYNC: valid i_sig != pred reloads pred = f(i_sig), clears match count and stays in SYNC; an all-zero mismatching i_sig returns to HUNT instead.
REQ-018 LOCKED: each valid word is compared with pred, then pred = f(pred) (flywheel; the input is never reloaded while locked).
REQ-019 LOCKED match clears the miss count. A mismatch pulses o_err and increments the miss count. When the miss count reaches LOSS_CNT, go to HUNT.
REQ-020 o_err and o_locked are registered: they reflect the valid word sampled on the previous rising edge.
REQ-021 o_err_cnt increments by 1 per o_err pulse and saturates at all-ones; it is not cleared on loss of lock.
REQ-022 Lock loss and a mismatch on the same word: o_err pulses, o_err_cnt increments, and o_locked falls in the same cycle.

Reset
REQ-023 i_rst high at a rising edge sets state HUNT, and clears pred, match count, miss count, o_locked, o_err and o_err_cnt to 0; this is sampled only on the clock edge.
REQ-024 Reset asserted mid-operation (any state, i_valid high or low) takes priority over all other updates in that cycle.

Configuration
REQ-025 Macro CA_PRNG_CHECKER_ERR_CNT_EN defined: o_err_cnt behaves as in REQ-021.
REQ-026 Macro CA_PRNG_CHECKER_ERR_CNT_EN undefined: no counter flops are built and o_err_cnt is tied to 0; o_err and all other behaviour are unchanged.

Structure
REQ-027 Shared package ca_prng_pkg holds the state enum (HUNT, SYNC, LOCKED) and the null-boundary rule function used by f.
REQ-028 f is implemented in one combinational sub-module, ca_rule_eval, parameterised by ARRAY_WIDTH and RULE. It is instantiated twice: once on i_sig and once on pred.

Verification (ARRAY_WIDTH=11, RULE=30, LOCK_CNT=4, LOSS_CNT=3)
REQ-029 Lock: seed 0x020 then the generator sequence 0x070, 0xC8, ... one word per cycle -> o_locked rises the cycle after the 5th valid word; o_err stays 0.
REQ-030 Bit error: when locked, inject one word with bit 0 flipped -> o_err is 1 for exactly one cycle, o_err_cnt = 1, o_locked stays 1, and subsequent correct words give no error.
REQ-031 Loss: when locked, drive 3 consecutive 0x7FF words -> o_err pulses 3 times, o_err_cnt = 3, and o_locked falls together with the 3rd pulse.
REQ-032 Gaps and zero: i_valid low for 5 cycles inside the lock sequence -> lock timing counts valid words only; all-zero words in HUNT -> state remains HUNT.
REQ-033 Reset: assert i_rst for 1 cycle while locked with o_err_cnt = 3 -> the next cycle shows o_locked = 0, o_err = 0, o_err_cnt = 0; relock needs 5 valid words.
REQ-034 Saturation (CNT_W=2): 5 isolated mismatches while locked -> o_err_cnt holds at 3; with the macro undefined, o_err_cnt stays 0 throughout.
